// File: rtl/cpu_param_if.sv
// Program ROM bus for cpu_param: the CPU drives the fetch address and
// the ROM answers combinationally with the instruction word.
interface cpu_param_if #(
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] adr;
    logic [ADDR_W+4:0] dout;

    modport master (output adr, input dout);
    modport slave  (input adr, output dout);
endinterface

// File: rtl/cpu_param.sv
// Parametrised single-cycle teaching CPU: seven registers, C/Z flags,
// bounded hardware return stack, HALT and sticky stack error reporting.
module cpu_param #(
    parameter int DATA_W      = 4,
    parameter int ADDR_W      = 4,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] btn,
    output logic [DATA_W-1:0] led,
    cpu_param_if.master       rom,
    output logic              halted,
    output logic              stack_err
);
    localparam int SP_W = $clog2(STACK_DEPTH + 1);

    localparam logic [4:0] OP_ADD  = 5'b01000;
    localparam logic [4:0] OP_OR   = 5'b01001;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_XOR  = 5'b01011;
    localparam logic [4:0] OP_INC  = 5'b01100;
    localparam logic [4:0] OP_NOT  = 5'b01101;
    localparam logic [4:0] OP_RROT = 5'b01110;
    localparam logic [4:0] OP_LROT = 5'b01111;
    localparam logic [4:0] OP_JNC  = 5'b10000;
    localparam logic [4:0] OP_JZ   = 5'b10001;
    localparam logic [4:0] OP_JMP  = 5'b10010;
    localparam logic [4:0] OP_CALL = 5'b10011;
    localparam logic [4:0] OP_MVI  = 5'b10100;
    localparam logic [4:0] OP_RET  = 5'b10101;
    localparam logic [4:0] OP_HALT = 5'b10110;
    localparam logic [4:0] OP_SUB  = 5'b10111;

    typedef enum logic {S_RUN, S_HALT} state_t;
    state_t state, state_nxt;

    logic [ADDR_W-1:0] pc, pc_inc, pc_nxt;
    logic [SP_W-1:0]   sp, sp_nxt;
    logic [ADDR_W-1:0] stack [2**SP_W];
    // r0-r4 live at 0-4 and r6 at 5; r5 is a free-running btn sampler
    logic [DATA_W-1:0] gpr [6];
    logic [DATA_W-1:0] r5;
    logic              c, z, c_nxt, z_nxt;

    logic [4:0]        op;
    logic [ADDR_W-1:0] imm;
    logic [2:0]        sss;
    logic [DATA_W-1:0] rs_val, wr_val;
    logic [DATA_W:0]   arith;
    logic [2:0]        wr_sel;
    logic              wr_en, set_z, push, err_set;

    assign op     = rom.dout[ADDR_W+4:ADDR_W];
    assign imm    = rom.dout[ADDR_W-1:0];
    assign sss    = imm[2:0];
    assign pc_inc = pc + ADDR_W'(1);

    always_comb begin
        case (sss)
            3'd5:    rs_val = r5;
            3'd6:    rs_val = gpr[5];
            3'd7:    rs_val = '0;
            default: rs_val = gpr[sss];
        endcase
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_sel  = sss;
        wr_val  = rs_val;
        arith   = '0;
        set_z   = 1'b0;
        c_nxt   = c;
        z_nxt   = z;
        pc_nxt  = pc_inc;
        sp_nxt  = sp;
        push    = 1'b0;
        err_set = 1'b0;
        if (op[4:3] == 2'b00) begin
            wr_en  = 1'b1;
            wr_sel = op[2:0];
        end else begin
            case (op)
                OP_ADD, OP_SUB: begin
                    arith  = (op == OP_ADD) ? {1'b0, gpr[0]} + {1'b0, rs_val}
                                            : {1'b0, gpr[0]} - {1'b0, rs_val};
                    wr_en  = 1'b1;
                    wr_sel = 3'd0;
                    wr_val = arith[DATA_W-1:0];
                    c_nxt  = arith[DATA_W];
                    set_z  = 1'b1;
                end
                OP_OR, OP_AND, OP_XOR: begin
                    wr_en  = 1'b1;
                    wr_sel = 3'd0;
                    wr_val = (op == OP_OR)  ? (gpr[0] | rs_val) :
                             (op == OP_AND) ? (gpr[0] & rs_val) : (gpr[0] ^ rs_val);
                    set_z  = 1'b1;
                end
                OP_INC: begin
                    arith  = {1'b0, rs_val} + (DATA_W+1)'(1);
                    wr_en  = 1'b1;
                    wr_val = arith[DATA_W-1:0];
                    c_nxt  = arith[DATA_W];
                    set_z  = 1'b1;
                end
                OP_NOT, OP_RROT, OP_LROT: begin
                    wr_en  = 1'b1;
                    wr_val = (op == OP_NOT)  ? ~rs_val :
                             (op == OP_RROT) ? {rs_val[0], rs_val[DATA_W-1:1]}
                                             : {rs_val[DATA_W-2:0], rs_val[DATA_W-1]};
                    set_z  = 1'b1;
                end
                OP_JNC: begin
                    if (!c) pc_nxt = imm;
                    c_nxt = 1'b0;
                end
                OP_JZ:  if (z) pc_nxt = imm;
                OP_JMP: pc_nxt = imm;
                OP_CALL: begin
                    if (sp < SP_W'(STACK_DEPTH)) begin
                        push   = 1'b1;
                        sp_nxt = sp + SP_W'(1);
                        pc_nxt = imm;
                    end else begin
                        err_set = 1'b1;
                    end
                end
                OP_MVI: begin
                    wr_en  = 1'b1;
                    wr_sel = 3'd0;
                    wr_val = DATA_W'(imm);
                end
                OP_RET: begin
                    if (sp != '0) begin
                        sp_nxt = sp - SP_W'(1);
                        pc_nxt = stack[sp - SP_W'(1)];
                    end else begin
                        err_set = 1'b1;
                    end
                end
                OP_HALT: pc_nxt = pc;
                default: ;
            endcase
        end
        if (set_z) z_nxt = (wr_val == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == S_RUN && op == OP_HALT) state_nxt = S_HALT;
    end

    always_comb begin
        halted  = (state == S_HALT);
        led     = gpr[5];
        rom.adr = pc;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc        <= '0;
            sp        <= '0;
            c         <= 1'b0;
            z         <= 1'b0;
            stack_err <= 1'b0;
            for (int unsigned i = 0; i < 6; i++) gpr[3'(i)] <= '0;
        end else if (state == S_RUN) begin
            pc <= pc_nxt;
            sp <= sp_nxt;
            c  <= c_nxt;
            z  <= z_nxt;
            if (err_set) stack_err <= 1'b1;
            // writes to r5 lose to btn, writes to r7 vanish
            if (wr_en && wr_sel != 3'd5 && wr_sel != 3'd7)
                gpr[(wr_sel == 3'd6) ? 3'd5 : wr_sel] <= wr_val;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && state == S_RUN && push) stack[sp] <= pc_inc;
    end

    always_ff @(posedge clk) begin
        r5 <= btn;
    end
endmodule

// File: tb/tb_cpu_param.sv
// Self-checking bench for cpu_param: ALU vector table, directed
// multi-cycle sequences and random programs against a behavioural model.
module tb_cpu_param;
    localparam int DW    = 4;
    localparam int AW    = 4;
    localparam int DEPTH = 2;
    localparam int MASK  = (1 << DW) - 1;

    localparam logic [4:0] OP_ADD  = 5'b01000, OP_OR   = 5'b01001, OP_AND  = 5'b01010;
    localparam logic [4:0] OP_XOR  = 5'b01011, OP_INC  = 5'b01100, OP_NOT  = 5'b01101;
    localparam logic [4:0] OP_RROT = 5'b01110, OP_LROT = 5'b01111, OP_JNC  = 5'b10000;
    localparam logic [4:0] OP_JZ   = 5'b10001, OP_JMP  = 5'b10010, OP_CALL = 5'b10011;
    localparam logic [4:0] OP_MVI  = 5'b10100, OP_RET  = 5'b10101, OP_HALT = 5'b10110;
    localparam logic [4:0] OP_SUB  = 5'b10111, OP_NOP  = 5'b11000;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] btn   = '0;
    logic [DW-1:0] led;
    logic          halted, stack_err;
    logic [AW+4:0] prog [16];

    cpu_param_if #(.ADDR_W(AW)) rom_bus ();
    assign rom_bus.dout = prog[rom_bus.adr];

    cpu_param #(.DATA_W(DW), .ADDR_W(AW), .STACK_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .btn(btn), .led(led),
        .rom(rom_bus), .halted(halted), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int m_r [8];
    bit m_c, m_z, m_halt, m_err;
    int m_pc;
    int m_stk [$];

    typedef struct {
        logic [4:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] dst;
        logic [3:0] res;
        logic       c;
        logic       z;
    } alu_vec_t;
    alu_vec_t tbl [13];

    function automatic logic [8:0] ins(input logic [4:0] o, input logic [3:0] i);
        return {o, i};
    endfunction

    function automatic logic [8:0] mov(input logic [2:0] d, input logic [2:0] s);
        return {2'b00, d, 1'b0, s};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) prog[i] = ins(OP_NOP, 4'd0);
    endtask

    task automatic model_reset(input int b);
        for (int i = 0; i < 8; i++) m_r[i] = 0;
        m_r[5] = b;
        m_c = 0; m_z = 0; m_halt = 0; m_err = 0; m_pc = 0;
        m_stk.delete();
    endtask

    task automatic do_reset(input logic [3:0] b);
        btn   = b;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        model_reset(int'(b));
    endtask

    // one instruction of architectural behaviour; r5 takes btn after the read
    task automatic model_step(input logic [8:0] w, input int b);
        int o, im, s, rs, npc, res, wd;
        o   = int'(w[8:4]);
        im  = int'(w[3:0]);
        s   = im % 8;
        rs  = (s == 7) ? 0 : m_r[s];
        npc = (m_pc + 1) % 16;
        res = 0;
        wd  = -1;
        if (!m_halt) begin
            if (o < 8) begin
                wd = o; res = rs;
            end else begin
                case (o)
                    OP_ADD:  begin res = m_r[0] + rs; m_c = res > MASK; res &= MASK; m_z = res == 0; wd = 0; end
                    OP_SUB:  begin res = m_r[0] - rs; m_c = res < 0; res &= MASK; m_z = res == 0; wd = 0; end
                    OP_OR:   begin res = m_r[0] | rs; m_z = res == 0; wd = 0; end
                    OP_AND:  begin res = m_r[0] & rs; m_z = res == 0; wd = 0; end
                    OP_XOR:  begin res = m_r[0] ^ rs; m_z = res == 0; wd = 0; end
                    OP_INC:  begin res = rs + 1; m_c = res > MASK; res &= MASK; m_z = res == 0; wd = s; end
                    OP_NOT:  begin res = (~rs) & MASK; m_z = res == 0; wd = s; end
                    OP_RROT: begin res = (rs >> 1) | ((rs & 1) << (DW - 1)); m_z = res == 0; wd = s; end
                    OP_LROT: begin res = ((rs << 1) & MASK) | (rs >> (DW - 1)); m_z = res == 0; wd = s; end
                    OP_JNC:  begin if (!m_c) npc = im; m_c = 0; end
                    OP_JZ:   if (m_z) npc = im;
                    OP_JMP:  npc = im;
                    OP_CALL: begin
                        if (m_stk.size() < DEPTH) begin m_stk.push_back(npc); npc = im; end
                        else m_err = 1;
                    end
                    OP_MVI:  begin res = im & MASK; wd = 0; end
                    OP_RET:  begin
                        if (m_stk.size() > 0) npc = m_stk.pop_back();
                        else m_err = 1;
                    end
                    OP_HALT: begin m_halt = 1; npc = m_pc; end
                    default: ;
                endcase
            end
            if (wd >= 0 && wd != 5 && wd != 7) m_r[wd] = res;
            m_pc = npc;
        end
        m_r[5] = b;
    endtask

    task automatic compare_model(input int run, input int cyc);
        string tag;
        tag = $sformatf("rand[%0d.%0d]", run, cyc);
        check({tag, ".led"},   int'(led),         m_r[6]);
        check({tag, ".adr"},   int'(rom_bus.adr), m_pc);
        check({tag, ".halt"},  int'(halted),      int'(m_halt));
        check({tag, ".err"},   int'(stack_err),   int'(m_err));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int exp_adr [9];
        int exp_err [9];
        int exp_hlt [9];
        logic [8:0] w;
        logic [3:0] b;

        tbl[0]  = '{OP_ADD,  4'h1, 4'hF, 3'd0, 4'h0, 1'b1, 1'b1};
        tbl[1]  = '{OP_ADD,  4'h3, 4'h4, 3'd0, 4'h7, 1'b0, 1'b0};
        tbl[2]  = '{OP_SUB,  4'h1, 4'h2, 3'd0, 4'hF, 1'b1, 1'b0};
        tbl[3]  = '{OP_SUB,  4'h5, 4'h5, 3'd0, 4'h0, 1'b0, 1'b1};
        tbl[4]  = '{OP_OR,   4'hA, 4'h5, 3'd0, 4'hF, 1'b0, 1'b0};
        tbl[5]  = '{OP_AND,  4'hA, 4'h5, 3'd0, 4'h0, 1'b0, 1'b1};
        tbl[6]  = '{OP_XOR,  4'hC, 4'hA, 3'd0, 4'h6, 1'b0, 1'b0};
        tbl[7]  = '{OP_INC,  4'h0, 4'hF, 3'd1, 4'h0, 1'b1, 1'b1};
        tbl[8]  = '{OP_INC,  4'h0, 4'h7, 3'd1, 4'h8, 1'b0, 1'b0};
        tbl[9]  = '{OP_NOT,  4'h0, 4'hF, 3'd1, 4'h0, 1'b0, 1'b1};
        tbl[10] = '{OP_NOT,  4'h0, 4'h5, 3'd1, 4'hA, 1'b0, 1'b0};
        tbl[11] = '{OP_RROT, 4'h0, 4'h1, 3'd1, 4'h8, 1'b0, 1'b0};
        tbl[12] = '{OP_LROT, 4'h0, 4'h8, 3'd1, 4'h1, 1'b0, 1'b0};

        // reset values, then asynchronous reset mid-program
        clear_prog();
        prog[0] = ins(OP_MVI, 4'd5);
        prog[1] = mov(3'd6, 3'd0);
        reset = 1'b0;
        btn   = 4'h3;
        tick();
        tick();
        check("rst.adr",  int'(rom_bus.adr), 0);
        check("rst.led",  int'(led),         0);
        check("rst.halt", int'(halted),      0);
        check("rst.err",  int'(stack_err),   0);
        reset = 1'b1;
        repeat (9) tick();
        check("run.adr", int'(rom_bus.adr), 9);
        check("run.led", int'(led),         5);
        #2 reset = 1'b0;
        #1;
        check("async.adr", int'(rom_bus.adr), 0);
        check("async.led", int'(led),         0);
        prog[0] = ins(OP_NOP, 4'd0);
        prog[1] = mov(3'd6, 3'd5);
        btn = 4'h9;
        tick();
        reset = 1'b1;
        tick();
        tick();
        check("post_rst.r5", int'(led), 9);

        // ALU table: result via led, Z then C decoded from the JZ/JNC landing address
        for (int k = 0; k < 13; k++) begin
            clear_prog();
            prog[0] = ins(OP_MVI, tbl[k].b);
            prog[1] = mov(3'd1, 3'd0);
            prog[2] = ins(OP_MVI, tbl[k].a);
            prog[3] = ins(tbl[k].op, 4'd1);
            prog[4] = mov(3'd6, tbl[k].dst);
            prog[5] = ins(OP_JZ, 4'd8);
            prog[6] = ins(OP_JNC, 4'd10);
            prog[8] = ins(OP_JNC, 4'd12);
            do_reset(4'h0);
            repeat (5) tick();
            check($sformatf("alu[%0d].res", k), int'(led), int'(tbl[k].res));
            repeat (2) tick();
            check($sformatf("alu[%0d].flags", k), int'(rom_bus.adr),
                  tbl[k].z ? (tbl[k].c ? 9 : 12) : (tbl[k].c ? 7 : 10));
        end

        // JNC clears C even when it falls through
        clear_prog();
        prog[0] = ins(OP_MVI, 4'hF);
        prog[1] = mov(3'd1, 3'd0);
        prog[2] = ins(OP_MVI, 4'h1);
        prog[3] = ins(OP_ADD, 4'd1);
        prog[4] = ins(OP_JNC, 4'd3);
        prog[5] = ins(OP_JNC, 4'd3);
        do_reset(4'h0);
        repeat (4) tick();
        check("jnc.at4", int'(rom_bus.adr), 4);
        tick();
        check("jnc.fall", int'(rom_bus.adr), 5);
        tick();
        check("jnc.jump", int'(rom_bus.adr), 3);

        // nested calls with overflow and underflow
        clear_prog();
        prog[1]  = ins(OP_CALL, 4'd8);
        prog[8]  = ins(OP_CALL, 4'd12);
        prog[12] = ins(OP_CALL, 4'd4);
        prog[13] = ins(OP_RET, 4'd0);
        prog[9]  = ins(OP_RET, 4'd0);
        prog[2]  = ins(OP_RET, 4'd0);
        prog[3]  = ins(OP_HALT, 4'd0);
        exp_adr = '{1, 8, 12, 13, 9, 2, 3, 3, 3};
        exp_err = '{0, 0, 0, 1, 1, 1, 1, 1, 1};
        exp_hlt = '{0, 0, 0, 0, 0, 0, 0, 1, 1};
        do_reset(4'h0);
        for (int s = 0; s < 9; s++) begin
            tick();
            check($sformatf("stk[%0d].adr", s),  int'(rom_bus.adr), exp_adr[s]);
            check($sformatf("stk[%0d].err", s),  int'(stack_err),   exp_err[s]);
            check($sformatf("stk[%0d].halt", s), int'(halted),      exp_hlt[s]);
        end

        // PC wrap, then HALT freezes adr while r5 keeps sampling btn
        clear_prog();
        do_reset(4'h0);
        repeat (15) tick();
        check("wrap.max", int'(rom_bus.adr), 15);
        tick();
        check("wrap.zero", int'(rom_bus.adr), 0);
        prog[5] = ins(OP_HALT, 4'd0);
        repeat (6) tick();
        check("halt.adr",  int'(rom_bus.adr), 5);
        check("halt.flag", int'(halted),      1);
        for (int s = 0; s < 3; s++) begin
            btn = 4'(4'h5 + 4'(s * 3));
            tick();
            check($sformatf("halt[%0d].adr", s), int'(rom_bus.adr), 5);
            check($sformatf("halt[%0d].r5", s),  int'(dut.r5),      int'(btn));
        end

        // register file corner cases: r5 read/write, r7 write
        clear_prog();
        prog[1] = mov(3'd6, 3'd5);
        prog[2] = ins(OP_MVI, 4'd3);
        prog[3] = mov(3'd5, 3'd0);
        prog[4] = mov(3'd6, 3'd5);
        prog[5] = mov(3'd7, 3'd0);
        prog[6] = mov(3'd6, 3'd0);
        do_reset(4'hA);
        repeat (2) tick();
        check("mov.r6_r5", int'(led), 10);
        repeat (3) tick();
        check("mov.r5_btn_wins", int'(led), 10);
        tick();
        check("mov.r7_noop", int'(led), 10);
        tick();
        check("mov.r0_kept", int'(led), 3);

        // random programs against the model
        for (int run = 0; run < 10; run++) begin
            for (int i = 0; i < 16; i++) begin
                w = 9'($urandom_range(0, 511));
                if (w[8:4] == OP_HALT && $urandom_range(0, 3) != 0) w = ins(OP_NOP, 4'd0);
                prog[i] = w;
            end
            b = 4'($urandom_range(0, 15));
            do_reset(b);
            for (int cyc = 0; cyc < 40; cyc++) begin
                btn = 4'($urandom_range(0, 15));
                model_step(prog[m_pc], int'(btn));
                tick();
                compare_model(run, cyc);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cpu_param.md
Name: cpu_param

Overview:
- Parametrised successor to the single-cycle 4-bit teaching CPU.
- Data width, program-address width and hardware call-stack depth are configurable.
- Adds a separate PC, a zero flag, correct carry/borrow, SUB, JZ, CALL/RET with a bounded return stack, HALT and sticky error reporting.
- Fetches one instruction per cycle from an external combinational program ROM (adr -> dout); drives LEDs and samples buttons as before.

Parameters:
- DATA_W, 4: width of registers, ALU, btn and led; must be >= 2.
- ADDR_W, 4: PC/ROM address width and immediate width; must be >= 3.
- STACK_DEPTH, 4: number of return-address entries; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- btn  in  DATA_W  button inputs, sampled into r5.
- led  out  DATA_W  current value of r6.
- adr  out  ADDR_W  current PC; ROM address.
- dout  in  5+ADDR_W  instruction at adr: op = dout[ADDR_W+4:ADDR_W], imm = dout[ADDR_W-1:0], sss = imm[2:0].
- halted  out  1  high once HALT has executed.
- stack_err  out  1  sticky; set on CALL overflow or RET underflow.

Behaviour:
- Reset is asynchronous, active-low, and may occur at any time including mid-program. It clears r0–r4, r6, PC, C, Z, stack pointer, halted and stack_err to 0. At the first clk edge after release, r5 <= btn.
- Registers r0–r6 are DATA_W wide. sss = 7 reads 0, and writes to it are discarded. r5 <= btn on every edge, including while halted; btn wins over any instruction write to r5.
- Single-cycle execution. All updates occur on the rising edge using state sampled before the edge. The default next PC is PC+1, mod 2^ADDR_W (wraps from max to 0).
- Immediates are zero-extended or truncated to the destination width.
- Z = (result == 0), updated by ADD, SUB, OR, AND, XOR, INC, NOT and rotates. C is updated only where stated below.
- Opcode map:
  - 00ddd MOV: rd <= rs (rs = sss). Flags unchanged.
  - 01000 ADD: r0 <= r0+rs. C = carry out of bit DATA_W-1 (DATA_W+1-bit sum).
  - 01001 OR, 01010 AND, 01011 XOR: r0 <= r0 op rs. C unchanged.
  - 01100 INC: rs <= rs+1. C = carry out (set only on all-ones -> 0).
  - 01101 NOT: rs <= ~rs. C unchanged.
  - 01110 RROT: rotate rs right by 1. 01111 LROT: rotate rs left by 1. C unchanged.
  - 10000 JNC: if !C then PC <= imm, else PC+1. C <= 0 in both cases.
  - 10001 JZ: if Z then PC <= imm, else PC+1. Flags unchanged.
  - 10010 JMP: PC <= imm.
  - 10011 CALL:
    - If sp < STACK_DEPTH: stack[sp] <= PC+1; sp <= sp+1; PC <= imm.
    - Otherwise: stack_err <= 1; no push; PC <= PC+1 (call skipped).
  - 10100 MVI: r0 <= imm. Flags unchanged.
  - 10101 RET:
    - If sp > 0: sp <= sp-1; PC <= stack[sp-1].
    - Otherwise: stack_err <= 1; PC <= PC+1.
  - 10110 HALT: halted <= 1; PC holds.
  - 10111 SUB: r0 <= r0-rs. C = borrow (1 when r0 < rs, unsigned).
  - 11xxx: NOP, PC+1.
- Halted state: PC, registers (other than r5), flags, stack and stack_err are frozen until reset. adr holds on the HALT address.
- Stack entries are not cleared by reset; only sp is cleared.
- stack_err stays set until reset; execution continues normally after an error.

Test Plan:
- Reset mid-run with r0=5, PC=9 -> all state 0 asynchronously, adr=0 before the next clk edge; after release, r5 follows btn.
- MVI 0xF; MOV r1,r0; MVI 1; ADD r1 (DATA_W=4) -> r0=0, C=1, Z=1; then JNC 3 falls through to PC+1 and C=0; a second JNC 3 jumps to 3.
- MVI 2; MOV r1,r0; MVI 1; SUB r1 -> r0=0xF, C=1, Z=0; MVI 7; ROT checks: RROT on 0b0001 -> 0b1000; LROT on 0b1000 -> 0b0001.
- STACK_DEPTH=2: CALL 8 from PC 1, CALL 12 from PC 8, CALL 4 from PC 12 -> third call skipped, stack_err=1, PC=13; RET -> PC=9; RET -> PC=2; RET -> stack_err stays 1, PC+1.
- PC wrap (ADDR_W=4): NOPs from 0 -> adr 15 then 0; HALT at PC 5 -> adr stays 5, halted=1, and r5 still tracks btn changes.
- MOV r6,r5 with btn=0xA -> led=0xA next cycle; MOV r5,r0 -> r5 still equals btn; MOV r7,r0 -> no register changes.
